// File: rtl/xbar_pkg.sv
// Shared crossbar types: controller state encoding, completion status codes
// and programming pulse polarity constants.
package xbar_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_WAIT_RD = 3'd2,
        S_COMPARE = 3'd3,
        S_PULSE   = 3'd4,
        S_SETTLE  = 3'd5,
        S_DONE    = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        ST_PASS  = 2'd0,
        ST_FAIL  = 2'd1,
        ST_ABORT = 2'd2
    } status_e;

    localparam logic POL_SET   = 1'b1;
    localparam logic POL_RESET = 1'b0;

    // Cell reads below target need more conductance (SET), otherwise RESET.
    function automatic logic pol_from_sign(input logic below_target);
        return below_target ? POL_SET : POL_RESET;
    endfunction

endpackage

// File: rtl/xbar_timer.sv
// Loadable down-counter with a zero flag. A load of N gives N+1 cycles
// until the flag is seen, which lets one counter time both the pulse and
// the settle phase of the programming loop.
module xbar_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);

    localparam logic [W-1:0] CNT_ZERO = W'(0);
    localparam logic [W-1:0] CNT_ONE  = W'(1);

    logic [W-1:0] count_r;

    // Count register: load wins, otherwise count down and stick at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= CNT_ZERO;
        end else if (load) begin
            count_r <= value;
        end else if (count_r != CNT_ZERO) begin
            count_r <= count_r - CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == CNT_ZERO);

endmodule

// File: rtl/xbar_prog_ctrl.sv
// Program-and-verify controller for one memristor crossbar cell at a time.
// Alternates read-verify and SET/RESET pulses until the read-back code is
// within tolerance, the pulse budget is spent, or the host aborts.
module xbar_prog_ctrl
    import xbar_pkg::*;
#(
    parameter int ROWS       = 16,
    parameter int COLS       = 16,
    parameter int CODE_W     = 8,
    parameter int TOL        = 2,
    parameter int MAX_PULSES = 8,
    parameter int PULSE_CYC  = 4,
    parameter int SETTLE_CYC = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [$clog2(ROWS)-1:0]         req_row,
    input  logic [$clog2(COLS)-1:0]         req_col,
    input  logic [CODE_W-1:0]               req_target,
    input  logic                            abort,
    output logic [$clog2(ROWS)-1:0]         cell_row,
    output logic [$clog2(COLS)-1:0]         cell_col,
    output logic                            rd_en,
    input  logic                            rd_valid,
    input  logic [CODE_W-1:0]               rd_code,
    output logic                            pulse_en,
    output logic                            pulse_pol,
    output logic                            done,
    output logic [1:0]                      status,
    output logic [$clog2(MAX_PULSES+1)-1:0] pulse_cnt
);

    localparam int RW      = $clog2(ROWS);
    localparam int CW      = $clog2(COLS);
    localparam int PCW     = $clog2(MAX_PULSES + 1);
    localparam int EW      = CODE_W + 1;
    localparam int TMR_MAX = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [PCW-1:0]   PCNT_ZERO = PCW'(0);
    localparam logic [PCW-1:0]   PCNT_ONE  = PCW'(1);
    localparam logic [PCW-1:0]   PCNT_MAX  = PCW'(MAX_PULSES);
    localparam logic [EW-1:0]    TOL_V     = EW'(TOL);
    localparam logic [EW-1:0]    ERR_ONE   = EW'(1);
    localparam logic [TMR_W-1:0] PULSE_LD  = TMR_W'(PULSE_CYC - 1);
    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);

    state_e              state_r;
    status_e             status_r;
    logic                req_ready_r;
    logic [RW-1:0]       cell_row_r;
    logic [CW-1:0]       cell_col_r;
    logic [CODE_W-1:0]   target_r;
    logic [CODE_W-1:0]   rd_code_r;
    logic                rd_en_r;
    logic                pulse_en_r;
    logic                pulse_pol_r;
    logic                done_r;
    logic [PCW-1:0]      pulse_cnt_r;

    logic [EW-1:0]       err_s;
    logic [EW-1:0]       err_mag_s;
    logic                err_neg_s;
    logic                in_tol_s;

    logic                tmr_load_s;
    logic [TMR_W-1:0]    tmr_val_s;
    logic                tmr_zero_s;

    // Comparator: signed error of the registered read against the target.
    always_comb begin
        err_s     = {1'b0, rd_code_r} - {1'b0, target_r};
        err_neg_s = err_s[EW-1];
        if (err_neg_s) begin
            err_mag_s = ~err_s + ERR_ONE;
        end else begin
            err_mag_s = err_s;
        end
        in_tol_s = (err_mag_s <= TOL_V);
    end

    // Phase timer control: arm for the pulse while comparing, re-arm for
    // settle on the last pulse cycle; free-running countdown otherwise.
    always_comb begin
        tmr_load_s = 1'b0;
        tmr_val_s  = PULSE_LD;
        if (state_r == S_COMPARE) begin
            tmr_load_s = 1'b1;
            tmr_val_s  = PULSE_LD;
        end else if ((state_r == S_PULSE) && tmr_zero_s) begin
            tmr_load_s = 1'b1;
            tmr_val_s  = SETTLE_LD;
        end else begin
            tmr_load_s = 1'b0;
            tmr_val_s  = PULSE_LD;
        end
    end

    xbar_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tmr_load_s),
        .value (tmr_val_s),
        .zero  (tmr_zero_s)
    );

    // Controller FSM with all front-end and host outputs registered so
    // they change together with the state they belong to.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            status_r    <= ST_PASS;
            req_ready_r <= 1'b0;
            cell_row_r  <= {RW{1'b0}};
            cell_col_r  <= {CW{1'b0}};
            target_r    <= {CODE_W{1'b0}};
            rd_code_r   <= {CODE_W{1'b0}};
            rd_en_r     <= 1'b0;
            pulse_en_r  <= 1'b0;
            pulse_pol_r <= 1'b0;
            done_r      <= 1'b0;
            pulse_cnt_r <= PCNT_ZERO;
        end else begin
            // Strobes are single-cycle unless a branch re-asserts them.
            rd_en_r    <= 1'b0;
            done_r     <= 1'b0;
            pulse_en_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (req_valid && req_ready_r) begin
                        req_ready_r <= 1'b0;
                        cell_row_r  <= req_row;
                        cell_col_r  <= req_col;
                        target_r    <= req_target;
                        pulse_cnt_r <= PCNT_ZERO;
                        status_r    <= ST_PASS;
                        rd_en_r     <= 1'b1;
                        state_r     <= S_READ;
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                S_READ: begin
                    if (abort) begin
                        status_r <= ST_ABORT;
                        done_r   <= 1'b1;
                        state_r  <= S_DONE;
                    end else begin
                        state_r  <= S_WAIT_RD;
                    end
                end
                S_WAIT_RD: begin
                    if (abort) begin
                        status_r  <= ST_ABORT;
                        done_r    <= 1'b1;
                        state_r   <= S_DONE;
                    end else if (rd_valid) begin
                        rd_code_r <= rd_code;
                        state_r   <= S_COMPARE;
                    end else begin
                        state_r   <= S_WAIT_RD;
                    end
                end
                S_COMPARE: begin
                    if (abort) begin
                        status_r    <= ST_ABORT;
                        done_r      <= 1'b1;
                        state_r     <= S_DONE;
                    end else if (in_tol_s) begin
                        status_r    <= ST_PASS;
                        done_r      <= 1'b1;
                        state_r     <= S_DONE;
                    end else if (pulse_cnt_r == PCNT_MAX) begin
                        status_r    <= ST_FAIL;
                        done_r      <= 1'b1;
                        state_r     <= S_DONE;
                    end else begin
                        pulse_en_r  <= 1'b1;
                        pulse_pol_r <= pol_from_sign(err_neg_s);
                        pulse_cnt_r <= pulse_cnt_r + PCNT_ONE;
                        state_r     <= S_PULSE;
                    end
                end
                S_PULSE: begin
                    if (abort) begin
                        status_r   <= ST_ABORT;
                        done_r     <= 1'b1;
                        state_r    <= S_DONE;
                    end else if (tmr_zero_s) begin
                        state_r    <= S_SETTLE;
                    end else begin
                        pulse_en_r <= 1'b1;
                        state_r    <= S_PULSE;
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        status_r <= ST_ABORT;
                        done_r   <= 1'b1;
                        state_r  <= S_DONE;
                    end else if (tmr_zero_s) begin
                        rd_en_r  <= 1'b1;
                        state_r  <= S_READ;
                    end else begin
                        state_r  <= S_SETTLE;
                    end
                end
                S_DONE: begin
                    req_ready_r <= 1'b1;
                    state_r     <= S_IDLE;
                end
                default: begin
                    req_ready_r <= 1'b0;
                    state_r     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign cell_row  = cell_row_r;
    assign cell_col  = cell_col_r;
    assign rd_en     = rd_en_r;
    assign pulse_en  = pulse_en_r;
    assign pulse_pol = pulse_pol_r;
    assign done      = done_r;
    assign status    = status_r;
    assign pulse_cnt = pulse_cnt_r;

endmodule

// File: tb/tb_xbar_prog_ctrl.sv
// Self-checking bench for xbar_prog_ctrl: directed scenarios plus random
// requests, each predicted by a read-sequence model of the verify loop.
module tb_xbar_prog_ctrl;

    localparam int ROWS       = 16;
    localparam int COLS       = 16;
    localparam int CODE_W     = 8;
    localparam int TOL        = 2;
    localparam int MAX_PULSES = 8;
    localparam int PULSE_CYC  = 4;
    localparam int SETTLE_CYC = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_row = 4'd0;
    logic [3:0] req_col = 4'd0;
    logic [7:0] req_target = 8'd0;
    logic       abort = 1'b0;
    logic [3:0] cell_row;
    logic [3:0] cell_col;
    logic       rd_en;
    logic       rd_valid = 1'b0;
    logic [7:0] rd_code = 8'd0;
    logic       pulse_en;
    logic       pulse_pol;
    logic       done;
    logic [1:0] status;
    logic [3:0] pulse_cnt;

    int total = 0;
    int bad   = 0;
    int codes [16];

    xbar_prog_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .CODE_W(CODE_W), .TOL(TOL),
        .MAX_PULSES(MAX_PULSES), .PULSE_CYC(PULSE_CYC), .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_row(req_row), .req_col(req_col), .req_target(req_target),
        .abort(abort), .cell_row(cell_row), .cell_col(cell_col),
        .rd_en(rd_en), .rd_valid(rd_valid), .rd_code(rd_code),
        .pulse_en(pulse_en), .pulse_pol(pulse_pol), .done(done),
        .status(status), .pulse_cnt(pulse_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {13'd0, req_ready, cell_row, cell_col, rd_en, pulse_en, pulse_pol,
                done, status, pulse_cnt};
    endfunction

    // One request; abort_mode 0 none, 1 abort in 2nd pulse cycle, 2 abort with 1st rd_valid.
    task automatic run_req(input int tgt, input int n_codes, input int lat,
                           input int abort_mode, input string tag);
        int exp_pol [16];
        int exp_pulses, exp_reads, exp_status, exp_done;
        int cyc, adc_cnt, read_idx, run, pulses_seen, last_fall, abort_cyc;
        int pol_bad, run_bad, settle_bad, rd_double, rd_seen, wait_cnt;
        int prev_rd, done_cyc, row, col;
        logic [1:0] st_at_done;
        logic [3:0] cnt_at_done;
        logic       pen_at_done;
        logic [7:0] rowcol_at_done;

        // Reference model: walk the read sequence through the verify rules.
        exp_pulses = 0;
        exp_reads  = 0;
        exp_status = 0;
        for (int i = 0; i <= MAX_PULSES; i++) begin
            int r;
            int d;
            r = codes[(i < n_codes) ? i : n_codes - 1];
            d = r - tgt;
            exp_reads = i + 1;
            if (d <= TOL && d >= -TOL) begin
                exp_status = 0;
                break;
            end
            if (exp_pulses == MAX_PULSES) begin
                exp_status = 1;
                break;
            end
            exp_pol[exp_pulses] = (d < 0) ? 1 : 0;
            exp_pulses++;
        end
        exp_done = exp_reads * (lat + 2) + exp_pulses * (PULSE_CYC + SETTLE_CYC) + 1;

        wait_cnt = 0;
        while (req_ready !== 1'b1 && wait_cnt < 50) begin
            @(negedge clk);
            wait_cnt++;
        end
        chk({tag, "_ready"}, req_ready, 1);

        row = $urandom_range(0, ROWS - 1);
        col = $urandom_range(0, COLS - 1);
        req_valid  = 1'b1;
        req_row    = row[3:0];
        req_col    = col[3:0];
        req_target = tgt[7:0];
        @(negedge clk);
        req_valid  = 1'b0;
        req_row    = 4'd0;
        req_col    = 4'd0;

        cyc = 1; adc_cnt = -1; read_idx = 0; run = 0; pulses_seen = 0;
        last_fall = -1; abort_cyc = -1; pol_bad = 0; run_bad = 0; settle_bad = 0;
        rd_double = 0; rd_seen = 0; prev_rd = 0; done_cyc = -1;
        st_at_done = 2'd3; cnt_at_done = 4'd15; pen_at_done = 1'b1; rowcol_at_done = 8'd0;

        while (done_cyc < 0 && cyc < 2000) begin
            rd_valid = 1'b0;
            abort    = 1'b0;
            if (adc_cnt > 0) begin
                adc_cnt--;
                if (adc_cnt == 0) begin
                    int v;
                    v = codes[(read_idx < n_codes) ? read_idx : n_codes - 1];
                    rd_valid = 1'b1;
                    rd_code  = v[7:0];
                    read_idx++;
                    adc_cnt  = -1;
                    if (abort_mode == 2 && read_idx == 1) begin
                        abort     = 1'b1;
                        abort_cyc = cyc;
                    end
                end
            end
            if (rd_en) begin
                rd_seen++;
                adc_cnt = lat;
                if (prev_rd != 0) rd_double++;
                if (last_fall >= 0) begin
                    if (cyc - last_fall != SETTLE_CYC) settle_bad++;
                    last_fall = -1;
                end
            end
            prev_rd = rd_en ? 1 : 0;
            if (pulse_en) begin
                run++;
                if (pulses_seen < 16 && pulses_seen < exp_pulses &&
                    ((pulse_pol ? 1 : 0) != exp_pol[pulses_seen])) pol_bad++;
                if (pulses_seen >= exp_pulses) pol_bad++;
                if (abort_mode == 1 && pulses_seen == 0 && run == 2) begin
                    abort     = 1'b1;
                    abort_cyc = cyc;
                end
            end else if (run > 0) begin
                if (abort_mode == 0 && run != PULSE_CYC) run_bad++;
                pulses_seen++;
                run = 0;
                last_fall = cyc;
            end
            if (done) begin
                done_cyc       = cyc;
                st_at_done     = status;
                cnt_at_done    = pulse_cnt;
                pen_at_done    = pulse_en;
                rowcol_at_done = {cell_row, cell_col};
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        rd_valid = 1'b0;
        abort    = 1'b0;

        chk({tag, "_done_seen"}, (done_cyc >= 0) ? 1 : 0, 1);
        chk({tag, "_cell"}, rowcol_at_done, {24'd0, row[3:0], col[3:0]});
        chk({tag, "_pen_at_done"}, pen_at_done, 0);
        if (abort_mode == 0) begin
            chk({tag, "_status"}, st_at_done, exp_status);
            chk({tag, "_pulse_cnt"}, cnt_at_done, exp_pulses);
            chk({tag, "_done_cyc"}, done_cyc, exp_done);
            chk({tag, "_pulses"}, pulses_seen, exp_pulses);
            chk({tag, "_reads"}, rd_seen, exp_reads);
            chk({tag, "_pol_run_settle"}, pol_bad + run_bad + settle_bad + rd_double, 0);
        end else begin
            chk({tag, "_status"}, st_at_done, 2);
            chk({tag, "_pulse_cnt"}, cnt_at_done, (abort_mode == 1) ? 1 : 0);
            chk({tag, "_done_cyc"}, done_cyc, abort_cyc + 1);
        end

        @(negedge clk);
        chk({tag, "_after_done"}, {done, req_ready}, 2'b01);
        chk({tag, "_held"}, {status, pulse_cnt}, {st_at_done, cnt_at_done});
    endtask

    initial begin
        int tgt, lat, hits;

        // Reset state.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs", all_outs(), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", req_ready, 1);

        // Immediate pass with a one-cycle ADC.
        codes[0] = 101;
        run_req(100, 1, 1, 0, "imm_pass");

        // SET convergence over two pulses.
        codes[0] = 90; codes[1] = 95; codes[2] = 99;
        run_req(100, 3, 1, 0, "set_conv");

        // RESET direction and tolerance edge.
        codes[0] = 103; codes[1] = 102;
        run_req(100, 2, 1, 0, "reset_tol");

        // Budget exhaustion.
        codes[0] = 50;
        run_req(200, 1, 1, 0, "budget");

        // Aborts: mid-pulse, and simultaneous with rd_valid.
        codes[0] = 50;
        run_req(100, 1, 1, 1, "abort_pulse");
        run_req(100, 1, 2, 2, "abort_rdv");

        // Reset while waiting for a read, read result arriving afterwards.
        @(negedge clk);
        req_valid  = 1'b1;
        req_row    = 4'd9;
        req_col    = 4'd5;
        req_target = 8'd77;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_mid_rd_en", rd_en, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_outs", all_outs(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", req_ready, 1);
        rd_valid = 1'b1;
        rd_code  = 8'd77;
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rd_valid = 1'b0;
            if (done || rd_en || pulse_en) hits++;
        end
        chk("rst_mid_quiet", hits, 0);
        chk("rst_mid_idle", {req_ready, pulse_cnt}, 5'b10000);

        // Random requests against the model.
        for (int n = 0; n < 20; n++) begin
            tgt = $urandom_range(0, 255);
            lat = $urandom_range(1, 3);
            for (int i = 0; i < 16; i++) begin
                int v;
                v = tgt + $urandom_range(0, 16) - 8;
                if (v < 0) v = 0;
                if (v > 255) v = 255;
                codes[i] = v;
            end
            run_req(tgt, 16, lat, 0, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
